mult_share_arbiter: RTL and testbench

- Shares one MULTB-style signed 9x9 multiplier among NREQ requesters, e.g. parallel conv-window engines in the MNIST CNN datapath.
- Arbitrates round-robin with optional burst lock and issues at most one product per cycle into the multiplier pipeline.
- Returns each 18-bit product to its originating requester with a fixed 3-cycle latency.
- Flags multiplier protocol violations with a sticky error bit.

---
 rtl/mult_share_arbiter.sv | 125 ++++++++++++
 tb/tb_mult_share_arbiter.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_share_arbiter.sv
// rtl/mult_share_arbiter.sv - round-robin arbiter sharing one signed 9x9 multiplier among NREQ requesters
module mult_share_arbiter #(
    parameter int NREQ = 4,
    parameter int IDXW = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ-1:0]        req_lock,
    input  logic [9*NREQ-1:0]      a_flat,
    input  logic [9*NREQ-1:0]      b_flat,
    output logic [NREQ-1:0]        gnt,
    output logic signed [8:0]      mul_a,
    output logic signed [8:0]      mul_b,
    output logic                   mul_start,
    input  logic                   mul_done,
    input  logic signed [17:0]     mul_result,
    output logic [NREQ-1:0]        rsp_valid,
    output logic signed [17:0]     rsp_data,
    output logic                   busy,
    output logic                   err
);

    logic [IDXW-1:0]   rr_ptr;
    logic [IDXW-1:0]   rr_next;
    logic [IDXW-1:0]   lock_owner;
    logic              lock_valid;
    logic [IDXW-1:0]   winner;
    logic              grant_any;
    logic              tag1_valid;
    logic [IDXW-1:0]   tag1_idx;
    logic              tag2_valid;
    logic [IDXW-1:0]   tag2_idx;
    logic [NREQ-1:0]   rsp_onehot;
    logic signed [8:0] a_arr [NREQ];
    logic signed [8:0] b_arr [NREQ];

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            a_arr[i] = a_flat[9*i +: 9];
            b_arr[i] = b_flat[9*i +: 9];
        end
    end

    // A held lock overrides the rotating scan; a dropped owner falls through to round-robin
    always_comb begin
        logic [IDXW-1:0] cand;
        int j;
        winner    = '0;
        grant_any = 1'b0;
        cand      = '0;
        j         = 0;
        if (lock_valid && req[lock_owner]) begin
            winner    = lock_owner;
            grant_any = 1'b1;
        end else begin
            for (int k = 0; k < NREQ; k++) begin
                j = int'(rr_ptr) + k;
                if (j >= NREQ) begin
                    j = j - NREQ;
                end
                cand = IDXW'(j);
                if (!grant_any && req[cand]) begin
                    winner    = cand;
                    grant_any = 1'b1;
                end
            end
        end
    end

    always_comb begin
        rr_next = (int'(winner) == NREQ - 1) ? '0 : winner + 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            gnt[i]        = reset && grant_any && (winner == IDXW'(i));
            rsp_onehot[i] = (tag2_idx == IDXW'(i));
        end
    end

    assign busy = tag1_valid | tag2_valid | mul_start;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mul_a      <= '0;
            mul_b      <= '0;
            mul_start  <= 1'b0;
            rsp_valid  <= '0;
            rsp_data   <= '0;
            err        <= 1'b0;
            rr_ptr     <= '0;
            lock_valid <= 1'b0;
            lock_owner <= '0;
            tag1_valid <= 1'b0;
            tag1_idx   <= '0;
            tag2_valid <= 1'b0;
            tag2_idx   <= '0;
        end else begin
            mul_start  <= grant_any;
            tag1_valid <= grant_any;
            tag2_valid <= tag1_valid;
            tag2_idx   <= tag1_idx;
            if (grant_any) begin
                mul_a      <= a_arr[winner];
                mul_b      <= b_arr[winner];
                tag1_idx   <= winner;
                rr_ptr     <= rr_next;
                lock_valid <= req_lock[winner];
                if (req_lock[winner]) begin
                    lock_owner <= winner;
                end
            end else if (lock_valid && !req[lock_owner]) begin
                lock_valid <= 1'b0;
            end
            // A product without a matching done is dropped rather than returned stale
            rsp_valid <= '0;
            if (tag2_valid && mul_done) begin
                rsp_valid <= rsp_onehot;
                rsp_data  <= mul_result;
            end
            if (tag2_valid != mul_done) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mult_share_arbiter.sv
// tb/tb_mult_share_arbiter.sv - directed and random checks of mult_share_arbiter against a queue-based model
module tb_mult_share_arbiter;

    localparam int NREQ = 4;
    localparam int IDXW = 2;

    logic                  clk;
    logic                  reset;
    logic [NREQ-1:0]       req;
    logic [NREQ-1:0]       req_lock;
    logic [9*NREQ-1:0]     a_flat;
    logic [9*NREQ-1:0]     b_flat;
    logic [NREQ-1:0]       gnt;
    logic signed [8:0]     mul_a;
    logic signed [8:0]     mul_b;
    logic                  mul_start;
    logic                  mul_done;
    logic signed [17:0]    mul_result;
    logic [NREQ-1:0]       rsp_valid;
    logic signed [17:0]    rsp_data;
    logic                  busy;
    logic                  err;

    mult_share_arbiter #(.NREQ(NREQ), .IDXW(IDXW)) dut (
        .clk(clk), .reset(reset), .req(req), .req_lock(req_lock),
        .a_flat(a_flat), .b_flat(b_flat), .gnt(gnt),
        .mul_a(mul_a), .mul_b(mul_b), .mul_start(mul_start),
        .mul_done(mul_done), .mul_result(mul_result),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural multiplier: one-cycle registered product, done follows start
    logic               mul_done_r;
    logic signed [17:0] mul_res_r;
    logic signed [17:0] ext_a, ext_b;
    logic               ovr_en, ovr_val;
    assign ext_a = mul_a;
    assign ext_b = mul_b;
    always @(posedge clk) begin
        if (!reset) begin
            mul_done_r <= 1'b0;
            mul_res_r  <= '0;
        end else begin
            mul_done_r <= mul_start;
            mul_res_r  <= ext_a * ext_b;
        end
    end
    assign mul_done   = ovr_en ? ovr_val : mul_done_r;
    assign mul_result = mul_res_r;

    typedef struct {int due; int idx; int prod;} ent_t;
    ent_t q[$];
    int   cyc, rr, lk_o;
    bit   lk_v, err_m;
    int   n_cmp, n_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick();
        if (lk_v && req[lk_o]) return lk_o;
        for (int k = 0; k < NREQ; k++) begin
            if (req[(rr + k) % NREQ]) return (rr + k) % NREQ;
        end
        return -1;
    endfunction

    // Called just after a negedge with inputs applied; checks this cycle then advances the model
    task automatic cycle();
        int w;
        logic [3:0] eg, ev;
        int ed;
        bit has_d, busy_e, start_e, has_t2, done_eff;
        logic signed [8:0] ta, tb;
        #1;
        w  = pick();
        eg = (w >= 0) ? 4'(1 << w) : 4'b0;
        ev = '0; ed = 0; has_d = 0;
        if (q.size() > 0 && q[0].due == cyc) begin
            ev = 4'(1 << q[0].idx);
            ed = q[0].prod;
            has_d = 1;
            void'(q.pop_front());
        end
        busy_e = 0; start_e = 0; has_t2 = 0;
        foreach (q[i]) begin
            if (q[i].due == cyc + 1 || q[i].due == cyc + 2) busy_e = 1;
            if (q[i].due == cyc + 2) start_e = 1;
            if (q[i].due == cyc + 1) has_t2 = 1;
        end
        chk("gnt", {28'b0, gnt}, {28'b0, eg});
        chk("rsp_valid", {28'b0, rsp_valid}, {28'b0, ev});
        if (has_d) chk("rsp_data", rsp_data, ed);
        chk("busy", {31'b0, busy}, {31'b0, busy_e});
        chk("mul_start", {31'b0, mul_start}, {31'b0, start_e});
        chk("err", {31'b0, err}, {31'b0, err_m});
        done_eff = ovr_en ? ovr_val : has_t2;
        if (has_t2 && !done_eff) begin
            err_m = 1;
            foreach (q[i]) if (q[i].due == cyc + 1) begin q.delete(i); break; end
        end
        if (!has_t2 && done_eff) err_m = 1;
        if (w >= 0) begin
            ta = a_flat[9*w +: 9];
            tb = b_flat[9*w +: 9];
            q.push_back('{cyc + 3, w, int'(ta) * int'(tb)});
            rr = (w + 1) % NREQ;
            if (req_lock[w]) begin lk_v = 1; lk_o = w; end
            else lk_v = 0;
        end else if (lk_v && !req[lk_o]) begin
            lk_v = 0;
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic cycle_g(input logic [3:0] eg);
        #1;
        chk("gnt_dir", {28'b0, gnt}, {28'b0, eg});
        cycle();
    endtask

    task automatic set_op(input int i, input int a, input int b);
        a_flat[9*i +: 9] = 9'(a);
        b_flat[9*i +: 9] = 9'(b);
    endtask

    task automatic model_reset();
        q.delete();
        rr = 0; lk_v = 0; lk_o = 0; err_m = 0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_gnt"}, {28'b0, gnt}, 32'd0);
        chk({tag, "_mul_a"}, {23'b0, mul_a}, 32'd0);
        chk({tag, "_mul_b"}, {23'b0, mul_b}, 32'd0);
        chk({tag, "_mul_start"}, {31'b0, mul_start}, 32'd0);
        chk({tag, "_rsp_valid"}, {28'b0, rsp_valid}, 32'd0);
        chk({tag, "_rsp_data"}, {14'b0, rsp_data}, 32'd0);
        chk({tag, "_busy"}, {31'b0, busy}, 32'd0);
        chk({tag, "_err"}, {31'b0, err}, 32'd0);
    endtask

    initial begin
        n_cmp = 0; n_err = 0; cyc = 0;
        model_reset();
        reset = 1'b0; req = '0; req_lock = '0; a_flat = '0; b_flat = '0;
        ovr_en = 1'b0; ovr_val = 1'b0;
        @(negedge clk);
        req = 4'b1111;
        #1;
        chk_all_zero("reset");
        @(negedge clk);
        reset = 1'b1;
        req = '0;

        // Round-robin over all four with A_i=i+1, B_i=10
        for (int i = 0; i < NREQ; i++) set_op(i, i + 1, 10);
        req = 4'b1111;
        for (int k = 0; k < 8; k++) cycle_g(4'(1 << (k % 4)));
        req = '0;
        repeat (3) cycle();

        // Single op 12 * -5 from requester 1
        set_op(1, 12, -5);
        req = 4'b0010;
        cycle_g(4'b0010);
        req = '0;
        repeat (4) cycle();

        // Lock burst from requester 2 while requester 0 waits
        set_op(0, 7, 3);
        set_op(2, -9, 11);
        req = 4'b0101;
        req_lock = 4'b0100;
        cycle_g(4'b0100);
        cycle_g(4'b0100);
        cycle_g(4'b0100);
        req_lock = 4'b0000;
        cycle_g(4'b0100);
        cycle_g(4'b0001);
        cycle_g(4'b0100);
        req = '0;
        repeat (3) cycle();

        // Extreme products back to back
        set_op(0, -256, -256);
        req = 4'b0001;
        cycle();
        set_op(3, 255, -256);
        req = 4'b1000;
        cycle();
        req = '0;
        cycle();
        #1;
        chk("ext_valid0", {28'b0, rsp_valid}, 32'b0001);
        chk("ext_data0", rsp_data, 65536);
        cycle();
        #1;
        chk("ext_valid1", {28'b0, rsp_valid}, 32'b1000);
        chk("ext_data1", rsp_data, -65280);
        cycle();
        cycle();

        // Random traffic with occasional locks
        for (int k = 0; k < 80; k++) begin
            req = 4'($urandom);
            req_lock = 4'($urandom & $urandom & $urandom);
            for (int i = 0; i < NREQ; i++) set_op(i, int'($urandom_range(0, 511)) - 256, int'($urandom_range(0, 511)) - 256);
            cycle();
        end
        req = '0; req_lock = '0;
        repeat (4) cycle();

        // Missing done on a tag2 cycle drops the response and sets err
        set_op(2, 5, 6);
        req = 4'b0100;
        cycle();
        req = '0;
        cycle();
        ovr_en = 1'b1; ovr_val = 1'b0;
        cycle();
        ovr_en = 1'b0;
        #1;
        chk("drop_err", {31'b0, err}, 32'd1);
        chk("drop_rsp", {28'b0, rsp_valid}, 32'd0);
        cycle();
        cycle();

        // Asynchronous reset between start and response
        for (int i = 0; i < NREQ; i++) set_op(i, i + 3, -7);
        req = 4'b1111;
        cycle();
        reset = 1'b0;
        #1;
        chk_all_zero("async_rst");
        model_reset();
        @(negedge clk);
        cyc++;
        reset = 1'b1;
        cycle_g(4'b0001);
        req = '0;
        repeat (3) cycle();

        // Spurious done with idle pipeline
        ovr_en = 1'b1; ovr_val = 1'b1;
        cycle();
        ovr_en = 1'b0;
        #1;
        chk("spurious_err", {31'b0, err}, 32'd1);
        cycle();
        cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
